load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter: MEM_WORDS, default 256, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents a load/store.
REQ-005 req_ready  output  1  controller accepts request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32 width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes response.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access rejected, no memory side effect.
REQ-014 mem_addr  output  32  word-aligned byte address to memory (bits [1:0] = 00).
REQ-015 mem_wdata  output  32  full word to memory.
REQ-016 mem_we  output  1  memory write enable, sampled by memory on clk rising edge.
REQ-017 mem_rdata  input  32  combinational read data for mem_addr.

Function
REQ-018 FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-019 req_ready = 1 only in IDLE with rst low; handshake = req_valid & req_ready; request fields latched on handshake.
REQ-020 From IDLE on handshake: illegal funct3 (load 011/110/111, store 011-111) or address >= MEM_WORDS*4 -> RESP with rsp_err=1; LW/LH/LB/LHU/LBU -> LOAD; SW -> STORE; SB/SH -> RMW_RD.
REQ-021 LOAD: register byte/half/word selected by addr[1:0], sign- or zero-extend per funct3 -> RESP; response visible 2 cycles after handshake.
REQ-022 STORE: mem_we=1 one cycle, mem_wdata=req_wdata -> RESP.
REQ-023 RMW_RD: capture mem_rdata -> RMW_WR; RMW_WR: mem_we=1 one cycle, mem_wdata = captured word with target byte/half lane replaced by req_wdata[7:0]/[15:0] -> RESP; response 3 cycles after handshake.
REQ-024 mem_we SHALL be 1 only in STORE and RMW_WR, exactly one cycle per store.
REQ-025 mem_addr = {latched addr[31:2], 2'b00} in every non-IDLE state; 0 in IDLE.
REQ-026 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid & rsp_ready -> IDLE, rsp_valid cleared next cycle.
REQ-027 No new request accepted until the cycle after the response handshake; max throughput one access per 3 cycles (loads).
REQ-028 req_valid or input changes outside IDLE SHALL be ignored.

Reset
REQ-029 rst asserted: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, req_ready=0, all latched fields 0, immediately (asynchronous).
REQ-030 Reset mid-operation aborts the access; reset during RMW_RD SHALL produce no memory write; pending response discarded.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=00 -> RESP with rsp_err=1, no memory access.
REQ-032 Macro undefined: misaligned low bits forced to natural alignment (half clears addr[0], word clears addr[1:0]) and access proceeds normally.

Structure
REQ-033 Package lsu_pkg: funct3 encoding constants, FSM state enum, lane-select helper constants.
REQ-034 One sub-module lsu_lane_mux (combinational): load extract/extend and store lane merge; FSM and registers stay in load_store_ctrl.

Verification
REQ-035 Mem word 0x10 = 0x8899AABB; LB addr 0x11 -> rsp_rdata 0xFFFFFFAA, rsp_valid 2 cycles after handshake; LBU same -> 0x000000AA.
REQ-036 Mem word 0x20 = 0x11223344; SH addr 0x22 wdata 0x0000BEEF -> one mem_we pulse, word becomes 0xBEEF3344, rsp_valid 3 cycles after handshake.
REQ-037 SW addr 0x400 with MEM_WORDS=256 -> rsp_err=1, mem_we never asserted, rsp_valid 1 cycle after handshake.
REQ-038 LW addr 0x06: with LSU_MISALIGN_TRAP_EN -> rsp_err=1; without -> data of word 0x04.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout; then released -> req_ready 1 next cycle.
REQ-040 rst asserted during RMW_RD of SB addr 0x30 -> mem_we stays 0, word 0x30 unchanged, outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: funct3 codes, FSM states
// and lane selects.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] LANE_B0 = 2'b00;
  localparam logic [1:0] LANE_B1 = 2'b01;
  localparam logic [1:0] LANE_B2 = 2'b10;
  localparam logic [1:0] LANE_B3 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } lsu_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
    else
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic: load byte/half extract with sign/zero extension
// and store lane merge into a previously read word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = rword[7:0];
    case (lane)
      LANE_B0: sel_b = rword[7:0];
      LANE_B1: sel_b = rword[15:8];
      LANE_B2: sel_b = rword[23:16];
      LANE_B3: sel_b = rword[31:24];
      default: sel_b = rword[7:0];
    endcase
    sel_h = lane[1] ? rword[31:16] : rword[15:0];

    load_data = rword;
    case (funct3[1:0])
      SZ_BYTE: load_data = funct3[2] ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      SZ_HALF: load_data = funct3[2] ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_data = rword;
    endcase

    merge_word = wdata;
    case (funct3[1:0])
      SZ_BYTE: begin
        merge_word = rword;
        case (lane)
          LANE_B0: merge_word[7:0]   = wdata[7:0];
          LANE_B1: merge_word[15:8]  = wdata[7:0];
          LANE_B2: merge_word[23:16] = wdata[7:0];
          LANE_B3: merge_word[31:24] = wdata[7:0];
          default: merge_word[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        merge_word = rword;
        if (lane[1]) merge_word[31:16] = wdata[15:0];
        else         merge_word[15:0]  = wdata[15:0];
      end
      default: merge_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// RV32 load/store controller with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        hs;
  logic        misalign;
  logic        bad;
  logic [31:0] addr_in;
  logic [31:0] lane_rword;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign hs        = req_valid && req_ready;

  always_comb begin
    addr_in  = req_addr;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
               ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_funct3[1:0] == SZ_HALF) addr_in[0]   = 1'b0;
    if (req_funct3[1:0] == SZ_WORD) addr_in[1:0] = 2'b00;
`endif
    bad = !f3_legal(req_we, req_funct3) || ({1'b0, req_addr} >= ADDR_LIMIT) || misalign;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (bad)                              state_d = S_RESP;
          else if (!req_we)                     state_d = S_LOAD;
          else if (req_funct3[1:0] == SZ_WORD)  state_d = S_STORE;
          else                                  state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_STORE:  state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Loads extract straight from memory; RMW merges into the captured word.
  assign lane_rword = (state_q == S_LOAD) ? mem_rdata : rword_q;

  lsu_lane_mux u_lane_mux (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .rword      (lane_rword),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  assign mem_we    = (state_q == S_STORE) || (state_q == S_RMW_WR);
  assign mem_addr  = (state_q == S_IDLE) ? '0 : {addr_q[31:2], 2'b00};
  assign mem_wdata = merge_word;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= addr_in;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= bad;
      end
      if (state_q == S_LOAD)   rdata_q <= load_data;
      if (state_q == S_RMW_RD) rword_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl with a behavioural 256-word memory.
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_ctrl #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for its response.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
    check({tag, "_rspclr"}, {31'h0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          w0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[1]  <= 32'hCAFEF00D;
    mem[4]  <= 32'h8899AABB;
    mem[8]  <= 32'h11223344;
    mem[12] <= 32'h55667788;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'd0);
    check("rst_rspv",  {31'h0, rsp_valid}, 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwe",   {31'h0, mem_we}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    access("lb", 1'b0, 3'b000, 32'h11, 32'h0, rd, err, lat);
    check("lb_data", rd, 32'hFFFFFFAA);
    check("lb_err",  {31'h0, err}, 32'd0);
    check("lb_lat",  lat, 2);

    access("lbu", 1'b0, 3'b100, 32'h11, 32'h0, rd, err, lat);
    check("lbu_data", rd, 32'h000000AA);

    access("lh", 1'b0, 3'b001, 32'h12, 32'h0, rd, err, lat);
    check("lh_data", rd, 32'hFFFF8899);

    access("lhu", 1'b0, 3'b101, 32'h10, 32'h0, rd, err, lat);
    check("lhu_data", rd, 32'h0000AABB);

    access("lw", 1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
    check("lw_data", rd, 32'h8899AABB);
    check("lw_lat",  lat, 2);

    w0 = we_cnt;
    access("sh", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, rd, err, lat);
    check("sh_word",  mem[8], 32'hBEEF3344);
    check("sh_pulse", we_cnt - w0, 1);
    check("sh_lat",   lat, 3);
    check("sh_rdata", rd, 32'h0);

    w0 = we_cnt;
    access("sb", 1'b1, 3'b000, 32'h25, 32'h00000123, rd, err, lat);
    check("sb_word",  mem[9], 32'h00002300);
    check("sb_pulse", we_cnt - w0, 1);

    w0 = we_cnt;
    access("sw", 1'b1, 3'b010, 32'h28, 32'hDEADBEEF, rd, err, lat);
    check("sw_word",  mem[10], 32'hDEADBEEF);
    check("sw_pulse", we_cnt - w0, 1);
    check("sw_lat",   lat, 2);

    w0 = we_cnt;
    access("sw_oob", 1'b1, 3'b010, 32'h400, 32'h12345678, rd, err, lat);
    check("oob_err",   {31'h0, err}, 32'd1);
    check("oob_lat",   lat, 1);
    check("oob_nowe",  we_cnt - w0, 0);
    check("oob_rdata", rd, 32'h0);

    access("ld_f3", 1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat);
    check("ldf3_err", {31'h0, err}, 32'd1);
    check("ldf3_lat", lat, 1);

    w0 = we_cnt;
    access("st_f3", 1'b1, 3'b100, 32'h10, 32'h0, rd, err, lat);
    check("stf3_err",  {31'h0, err}, 32'd1);
    check("stf3_nowe", we_cnt - w0, 0);

    access("lw_mis", 1'b0, 3'b010, 32'h06, 32'h0, rd, err, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err",  {31'h0, err}, 32'd1);
    check("mis_data", rd, 32'h0);
`else
    check("mis_err",  {31'h0, err}, 32'd0);
    check("mis_data", rd, 32'hCAFEF00D);
`endif

    // Back-pressure on the response, with input noise while busy.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h04; req_we = 1'b1;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, rsp_valid}, 32'd1);
      check("stall_data",  rsp_rdata, 32'h8899AABB);
      check("stall_ready", {31'h0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_valid", {31'h0, rsp_valid}, 32'd0);
    check("rel_ready", {31'h0, req_ready}, 32'd1);

    // Reset while the SB is in its read phase.
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h30; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    check("rmw_rd_maddr", mem_addr, 32'h30);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    check("ar_mwe",   {31'h0, mem_we}, 32'd0);
    check("ar_maddr", mem_addr, 32'h0);
    check("ar_rspv",  {31'h0, rsp_valid}, 32'd0);
    check("ar_ready", {31'h0, req_ready}, 32'd0);
    check("ar_err",   {31'h0, rsp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_word",  mem[12], 32'h55667788);
    check("ar_nowe",  we_cnt - w0, 0);
    check("ar_idle",  {31'h0, req_ready}, 32'd1);
    check("ar_rspv2", {31'h0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
